wb_arbiter: RTL and testbench

Writeback arbiter between the per-unit register writeback FIFOs and the integer register file write port. Each cycle it selects one non-empty source FIFO by round-robin, pops its head entry, and drives a registered register-file write and a commit-retire report for that entry's commit ID. It sits directly downstream of the writeback FIFOs (ALU, MUL, DIV, LSU) and upstream of the register file and the commit tracker.

---
 rtl/wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Writeback arbiter between the per-unit writeback FIFOs (ALU, MUL, DIV, LSU)
// and the integer register file write port. Each cycle one non-empty source is
// picked round-robin, its head entry is popped, and a registered register-file
// write plus a commit-retire report for that entry are produced next cycle.
//
// Ports
//   clk              core clock, all state on rising edge
//   rst              synchronous active-high reset
//   src_empty_i      per-source FIFO empty flags
//   src_wdata_i      per-source head write data, source i at [i*DW +: DW]
//   src_waddr_i      per-source head destination register
//   src_commit_id_i  per-source head commit ID
//   src_pop_o        one-hot pop to the granted FIFO (combinational)
//   hold_i           debug/halt hold, suppresses all grants
//   reg_we_o         register file write enable (registered, never for x0)
//   reg_waddr_o      register file write address
//   reg_wdata_o      register file write data
//   commit_valid_o   commit-retire strobe (registered)
//   commit_id_o      retired commit ID
//   busy_o           any source non-empty or output stage valid

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 6
`endif

module wb_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_SRC-1:0]                    src_empty_i,
  input  logic [NUM_SRC*`REG_DATA_WIDTH-1:0]    src_wdata_i,
  input  logic [NUM_SRC*`REG_ADDR_WIDTH-1:0]    src_waddr_i,
  input  logic [NUM_SRC*`COMMIT_ID_WIDTH-1:0]   src_commit_id_i,
  output logic [NUM_SRC-1:0]                    src_pop_o,
  input  logic                                  hold_i,
  output logic                                  reg_we_o,
  output logic [`REG_ADDR_WIDTH-1:0]            reg_waddr_o,
  output logic [`REG_DATA_WIDTH-1:0]            reg_wdata_o,
  output logic                                  commit_valid_o,
  output logic [`COMMIT_ID_WIDTH-1:0]           commit_id_o,
  output logic                                  busy_o
);

  localparam int DW = `REG_DATA_WIDTH;
  localparam int AW = `REG_ADDR_WIDTH;
  localparam int CW = `COMMIT_ID_WIDTH;
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]      rr_ptr_r;
  logic [NUM_SRC-1:0] req_s;
  logic               grant_valid_s;
  logic [PW-1:0]      grant_idx_s;
  logic [PW-1:0]      rr_next_s;
  logic [DW-1:0]      sel_wdata_s;
  logic [AW-1:0]      sel_waddr_s;
  logic [CW-1:0]      sel_cid_s;

  logic               reg_we_r;
  logic [AW-1:0]      reg_waddr_r;
  logic [DW-1:0]      reg_wdata_r;
  logic               commit_valid_r;
  logic [CW-1:0]      commit_id_r;

  // Returns {found, index} of the first requester searching from ptr upward
  // modulo NUM_SRC. Walking the search order backwards lets the
  // highest-priority requester be the last one written.
  function automatic logic [PW:0] pick_grant(input logic [NUM_SRC-1:0] req,
                                             input logic [PW-1:0]      ptr);
    logic [PW:0] res;
    int          idx;
    res = {1'b0, {PW{1'b0}}};
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      idx = (idx >= NUM_SRC) ? idx - NUM_SRC : idx;
      res = req[idx] ? {1'b1, PW'(idx)} : res;
    end
    return res;
  endfunction

  // Request masking, grant selection, pop decode and next round-robin pointer.
  always_comb begin
    req_s = ~src_empty_i & {NUM_SRC{~hold_i}} & {NUM_SRC{~rst}};
    {grant_valid_s, grant_idx_s} = pick_grant(req_s, rr_ptr_r);
    if (grant_valid_s) begin
      src_pop_o = NUM_SRC'(1) << grant_idx_s;
    end else begin
      src_pop_o = '0;
    end
    if (grant_idx_s == PW'(NUM_SRC - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_idx_s + PW'(1);
    end
  end

  // Head-entry mux for the granted source, using constant slices only.
  always_comb begin
    sel_wdata_s = '0;
    sel_waddr_s = '0;
    sel_cid_s   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx_s == PW'(i)) begin
        sel_wdata_s = src_wdata_i[i*DW +: DW];
        sel_waddr_s = src_waddr_i[i*AW +: AW];
        sel_cid_s   = src_commit_id_i[i*CW +: CW];
      end else begin
        sel_wdata_s = sel_wdata_s;
        sel_waddr_s = sel_waddr_s;
        sel_cid_s   = sel_cid_s;
      end
    end
  end

  // Pointer and output stage; data fields hold their last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r       <= '0;
      reg_we_r       <= 1'b0;
      reg_waddr_r    <= '0;
      reg_wdata_r    <= '0;
      commit_valid_r <= 1'b0;
      commit_id_r    <= '0;
    end else if (grant_valid_s) begin
      rr_ptr_r       <= rr_next_s;
      // x0 entries retire but never write the register file
      reg_we_r       <= (sel_waddr_s != '0);
      reg_waddr_r    <= sel_waddr_s;
      reg_wdata_r    <= sel_wdata_s;
      commit_valid_r <= 1'b1;
      commit_id_r    <= sel_cid_s;
    end else begin
      reg_we_r       <= 1'b0;
      commit_valid_r <= 1'b0;
    end
  end

  assign reg_we_o       = reg_we_r;
  assign reg_waddr_o    = reg_waddr_r;
  assign reg_wdata_o    = reg_wdata_r;
  assign commit_valid_o = commit_valid_r;
  assign commit_id_o    = commit_id_r;
  assign busy_o         = (|(~src_empty_i)) | commit_valid_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a table of per-cycle input records with
// expected pops, a scoreboard of expected registered outputs, and a few
// hand-written sequences for x0 writes, pointer wrap and mid-flight reset.

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 6
`endif

module tb_wb_arbiter;

  typedef struct packed {
    logic       rst;
    logic       hold;
    logic [3:0] empty;
    logic [3:0] exp_pop;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic        cv;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  cid;
  } out_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         hold;
  logic [3:0]   src_empty;
  logic [127:0] src_wdata;
  logic [19:0]  src_waddr;
  logic [23:0]  src_cid;
  logic [3:0]   src_pop;
  logic         reg_we;
  logic [4:0]   reg_waddr;
  logic [31:0]  reg_wdata;
  logic         commit_valid;
  logic [5:0]   commit_id;
  logic         busy;

  logic [31:0]  cur_wdata [4];
  logic [4:0]   cur_waddr [4];
  logic [5:0]   cur_cid   [4];

  vec_t tbl [$];
  out_t sb  [$];
  out_t model;
  int   n_vec = 0;
  int   n_err = 0;

  wb_arbiter #(.NUM_SRC(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .src_empty_i     (src_empty),
    .src_wdata_i     (src_wdata),
    .src_waddr_i     (src_waddr),
    .src_commit_id_i (src_cid),
    .src_pop_o       (src_pop),
    .hold_i          (hold),
    .reg_we_o        (reg_we),
    .reg_waddr_o     (reg_waddr),
    .reg_wdata_o     (reg_wdata),
    .commit_valid_o  (commit_valid),
    .commit_id_o     (commit_id),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic gen_data(input int v);
    for (int i = 0; i < 4; i++) begin
      cur_wdata[i] = {16'hC0DE, 8'(v), 8'(i)};
      cur_waddr[i] = 5'((v * 3 + i * 7) % 32);
      cur_cid[i]   = 6'((v * 4 + i) % 64);
    end
  endtask

  // One cycle: drive inputs, check pop/busy mid-cycle, push the expected
  // registered result, then pop and compare it after the clock edge.
  task automatic step(input logic r, input logic h, input logic [3:0] e,
                      input logic [3:0] p, input string tag);
    out_t nxt;
    out_t got;
    int   g;
    rst       = r;
    hold      = h;
    src_empty = e;
    src_wdata = {cur_wdata[3], cur_wdata[2], cur_wdata[1], cur_wdata[0]};
    src_waddr = {cur_waddr[3], cur_waddr[2], cur_waddr[1], cur_waddr[0]};
    src_cid   = {cur_cid[3], cur_cid[2], cur_cid[1], cur_cid[0]};
    #3;
    check({tag, " pop"}, 64'(src_pop), 64'(p));
    check({tag, " busy"}, 64'(busy), 64'((|(~e)) | model.cv));
    g = 0;
    for (int i = 0; i < 4; i++) if (p[i]) g = i;
    nxt = model;
    if (r) begin
      nxt = '0;
    end else if (p != 4'b0000) begin
      nxt.cv    = 1'b1;
      nxt.we    = (cur_waddr[g] != 5'd0);
      nxt.waddr = cur_waddr[g];
      nxt.wdata = cur_wdata[g];
      nxt.cid   = cur_cid[g];
    end else begin
      nxt.we = 1'b0;
      nxt.cv = 1'b0;
    end
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    got   = sb.pop_front();
    model = got;
    check({tag, " we"},    64'(reg_we),       64'(got.we));
    check({tag, " cv"},    64'(commit_valid), 64'(got.cv));
    check({tag, " waddr"}, 64'(reg_waddr),    64'(got.waddr));
    check({tag, " wdata"}, 64'(reg_wdata),    64'(got.wdata));
    check({tag, " cid"},   64'(commit_id),    64'(got.cid));
  endtask

  initial begin
    // reset with all sources full: no pops during reset
    tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000});
    // all empty for 10 cycles
    for (int i = 0; i < 10; i++) tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000});
    // all four requesting: fair rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'(4'b0001 << (i % 4))});
    tbl.push_back('{1'b0, 1'b0, 4'b1011, 4'b0100}); // src2 alone, ptr -> 3
    tbl.push_back('{1'b0, 1'b0, 4'b0110, 4'b1000}); // src3 & src0: 3 wins, ptr wraps to 0
    tbl.push_back('{1'b0, 1'b0, 4'b0110, 4'b0001}); // then 0, ptr -> 1
    tbl.push_back('{1'b0, 1'b0, 4'b1010, 4'b0100}); // src0 & src2 from ptr 1 -> 2
    tbl.push_back('{1'b0, 1'b0, 4'b1001, 4'b0010}); // src1 & src2 from ptr 3 -> 1
    tbl.push_back('{1'b0, 1'b0, 4'b1101, 4'b0010}); // single source every cycle
    tbl.push_back('{1'b0, 1'b0, 4'b1101, 4'b0010});
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, 4'b1100, 4'b0000}); // hold
    tbl.push_back('{1'b0, 1'b0, 4'b1100, 4'b0001}); // resume at ptr 2 -> src0
    tbl.push_back('{1'b0, 1'b0, 4'b1100, 4'b0010});
    tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000}); // reset mid-stream
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0001}); // ptr back at 0
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b0000});

    model     = '0;
    rst       = 1'b1;
    hold      = 1'b0;
    src_empty = 4'b1111;
    gen_data(0);
    src_wdata = '0;
    src_waddr = '0;
    src_cid   = '0;
    @(posedge clk);
    #1;

    for (int v = 0; v < tbl.size(); v++) begin
      gen_data(v);
      step(tbl[v].rst, tbl[v].hold, tbl[v].empty, tbl[v].exp_pop, $sformatf("row%0d", v));
      if (v == 10) check("rr after idle", 64'(dut.rr_ptr_r), 64'd0);
      if (v == 28) check("rr frozen by hold", 64'(dut.rr_ptr_r), 64'd2);
    end

    // single source 2 write
    gen_data(50);
    cur_waddr[2] = 5'd5;
    cur_wdata[2] = 32'hDEADBEEF;
    cur_cid[2]   = 6'd3;
    step(1'b0, 1'b0, 4'b1011, 4'b0100, "src2");
    check("src2 wdata", 64'(reg_wdata), 64'h0000_0000_DEAD_BEEF);
    check("src2 waddr", 64'(reg_waddr), 64'd5);

    // x0 destination retires without writing; ptr 3 wraps to find src1
    gen_data(51);
    cur_waddr[1] = 5'd0;
    cur_cid[1]   = 6'd7;
    step(1'b0, 1'b0, 4'b1101, 4'b0010, "x0");
    check("x0 cid", 64'(commit_id), 64'd7);
    check("x0 we", 64'(reg_we), 64'd0);

    // reset while commit_valid is high
    gen_data(52);
    step(1'b1, 1'b0, 4'b0000, 4'b0000, "rst_busy");
    check("rr after reset", 64'(dut.rr_ptr_r), 64'd0);
    step(1'b0, 1'b0, 4'b1111, 4'b0000, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
